mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit for the single-cycle CPU datapath; the sequential counterpart to the combinational ALU.
- Executes MULT, MULTU, DIV and DIVU over 32 iterations and holds the results in architectural HI/LO registers.
- Control drives the start/op handshake and stalls the PC while busy. MFHI/MFLO read hi/lo directly; MTHI/MTLO write through hi_we/lo_we.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request; sampled only when not busy
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- a  in  WIDTH  multiplicand / dividend (rs)
- b  in  WIDTH  multiplier / divisor (rt)
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in progress; CPU stalls
- done  out  1  one-cycle pulse; hi/lo hold the new result
- hi  out  WIDTH  HI register (product[63:32] / remainder)
- lo  out  WIDTH  LO register (product[31:0] / quotient)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0. Reset mid-operation aborts the operation: no done, hi/lo cleared.
- States:
  - IDLE: busy=0. On start, latch op, latch |a| and |b| (magnitudes for signed ops), record result sign bits, clear counter, go to CALC.
  - CALC: busy=1. One shift-add (multiply) or restoring shift-subtract (divide) step per cycle. Counter increments; at counter==WIDTH-1 go to FIX.
  - FIX: busy=1. Apply signs and write hi/lo. Go to DONE.
  - DONE: busy=0, done=1 for exactly this cycle. start here is accepted exactly as in IDLE; otherwise go to IDLE.
- Latency: start sampled at edge N gives done=1 during the cycle after edge N+WIDTH+1, i.e. 34 cycles for WIDTH=32. busy is high from edge N through edge N+WIDTH+1.
- start while busy is ignored. There is no queueing.
- Multiply result: 64-bit {hi,lo}.
  - Unsigned: plain product.
  - Signed: product of magnitudes, negated as 64 bits when sign(a)^sign(b).
- Divide result: lo=quotient, hi=remainder, both truncated toward zero.
  - Quotient sign = sign(a)^sign(b).
  - Remainder sign = sign(a).
  - Divide by zero (b==0, any signedness): lo=all-ones, hi=a unmodified. Latency is unchanged.
  - DIV of most-negative by -1: lo=0x80000000, hi=0 (wrap, no trap).
- MTHI/MTLO:
  - hi_we/lo_we write wdata at the edge when state is IDLE or DONE and start=0.
  - Writes while busy are dropped.
  - If start and a write enable are high together, start wins and the write is dropped.
- hi/lo hold their value at all other times. They do not change during CALC.
- Magnitude of the most-negative operand is computed as an unsigned WIDTH value; no extra bit is needed.

Decomposition:
- Shared package mdu_pkg holds:
  - op encodings MDU_MULTU/MDU_MULT/MDU_DIVU/MDU_DIV;
  - state encodings IDLE/CALC/FIX/DONE;
  - the counter width expression clog2(WIDTH).
- One sub-module, mdu_step: combinational single-iteration datapath (add-shift or subtract-shift with restore select). The top-level holds the FSM, counter, operand/partial registers and HI/LO.

Test Plan:
1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. done exactly 34 cycles after start edge; busy high for 33 cycles.
2. MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT a=0x80000000 b=0x80000000 -> hi=0x40000000, lo=0.
3. DIVU a=7 b=2 -> lo=3, hi=1. DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
4. DIV a=0x12345678 b=0 -> lo=0xFFFFFFFF, hi=0x12345678. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
5. MTHI wdata=0xA5A5A5A5 in IDLE -> hi=0xA5A5A5A5 next cycle. Same write and a second start issued mid-CALC -> both ignored; result of the first op unchanged.
6. rst asserted at CALC cycle 10 -> next cycle busy=0, done=0, hi=lo=0. A following MULTU 3*5 -> lo=15, hi=0 with full 34-cycle latency.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: operation
// encodings, FSM states and small decode helpers.
package mdu_pkg;

    // Operation encodings as driven by the control unit on op[1:0]
    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_MULT  = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_DIV   = 2'b11
    } mdu_op_t;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } mdu_state_t;

    // Width of the iteration counter; it must count 0 .. width-1
    function automatic int mdu_cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    // High op bit selects divide, low op bit selects signed operation
    function automatic logic mdu_is_div(input mdu_op_t op);
        return op[1];
    endfunction

    function automatic logic mdu_is_signed(input mdu_op_t op);
        return op[0];
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the multiply/divide datapath.
// Multiply: {part_hi, part_lo} is the running product with the multiplier in
// the low half; add the multiplicand when the current multiplier bit is set,
// then shift the whole pair right by one.
// Divide: part_hi is the partial remainder, part_lo shifts the dividend out of
// its top and the quotient bits into its bottom (restoring division).
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  mdu_op_t          op,
    input  logic [WIDTH-1:0] opnd,
    input  logic [WIDTH-1:0] part_hi,
    input  logic [WIDTH-1:0] part_lo,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] diff;

    // Compute both candidate next states and pick the one for the current op
    always_comb begin
        sum     = {1'b0, part_hi} + (part_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        shifted = {part_hi, part_lo[WIDTH-1]};
        fits    = (shifted >= {1'b0, opnd});
        // The true difference is below the divisor, so the low WIDTH bits are exact
        diff    = shifted[WIDTH-1:0] - opnd;
        if (mdu_is_div(op)) begin
            next_hi = fits ? diff : shifted[WIDTH-1:0];
            next_lo = {part_lo[WIDTH-2:0], fits};
        end else begin
            next_hi = sum[WIDTH:1];
            next_lo = {sum[0], part_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Operands are reduced to magnitudes on start, iterated WIDTH times through
// mdu_step, and signs are applied in the FIX state before HI/LO are written.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = mdu_cnt_width(WIDTH);

    mdu_state_t       state_q;
    mdu_op_t          op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH-1:0] part_hi_q;
    logic [WIDTH-1:0] part_lo_q;
    logic [WIDTH-1:0] a_raw_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             b_zero_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;

    mdu_op_t          op_in;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   quo_signed;
    logic [WIDTH-1:0]   rem_signed;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    // Decode the incoming request and take operand magnitudes for signed ops;
    // the most-negative value maps onto itself, which is its correct unsigned magnitude
    always_comb begin
        op_in = mdu_op_t'(op);
        a_neg = mdu_is_signed(op_in) & a[WIDTH-1];
        b_neg = mdu_is_signed(op_in) & b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    mdu_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .op      (op_q),
        .opnd    (opnd_q),
        .part_hi (part_hi_q),
        .part_lo (part_lo_q),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    // Apply result signs and the divide-by-zero convention for the FIX write
    always_comb begin
        prod        = {part_hi_q, part_lo_q};
        prod_signed = neg_quo_q ? -prod : prod;
        quo_signed  = neg_quo_q ? -part_lo_q : part_lo_q;
        rem_signed  = neg_rem_q ? -part_hi_q : part_hi_q;
        fix_hi      = prod_signed[2*WIDTH-1:WIDTH];
        fix_lo      = prod_signed[WIDTH-1:0];
        if (mdu_is_div(op_q)) begin
            if (b_zero_q) begin
                fix_hi = a_raw_q;
                fix_lo = '1;
            end else begin
                fix_hi = rem_signed;
                fix_lo = quo_signed;
            end
        end
    end

    // Sequencer, iteration registers and HI/LO, all with registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= MDU_MULTU;
            cnt_q     <= '0;
            opnd_q    <= '0;
            part_hi_q <= '0;
            part_lo_q <= '0;
            a_raw_q   <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            b_zero_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        op_q      <= op_in;
                        opnd_q    <= mdu_is_div(op_in) ? b_mag : a_mag;
                        part_hi_q <= '0;
                        part_lo_q <= mdu_is_div(op_in) ? a_mag : b_mag;
                        a_raw_q   <= a;
                        neg_quo_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        b_zero_q  <= (b == '0);
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= CALC;
                    end else begin
                        if (hi_we) begin
                            hi_q <= wdata;
                        end
                        if (lo_we) begin
                            lo_q <= wdata;
                        end
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    part_hi_q <= step_hi;
                    part_lo_q <= step_lo;
                    cnt_q     <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: each request pushes its hand-computed
// HI/LO result into a queue, and a monitor pops and compares on every done.
module tb_mul_div_unit;

    localparam int WIDTH      = 32;
    localparam int DONE_INDEX = WIDTH + 2;
    localparam int BUSY_COUNT = WIDTH + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [1:0]        op;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              hi_we;
    logic              lo_we;
    logic [WIDTH-1:0]  wdata;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;

    mul_div_unit #(
        .WIDTH(WIDTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: each done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                checkOutput("spurious_done", 64'(done), 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput(mon_e.name, {hi, lo}, {mon_e.hi, mon_e.lo});
            end
        end
    end

    // Issue one request at the current negedge and follow it to done.
    // mode 1 also raises hi_we with start, then injects start and writes mid-CALC,
    // checking that HI keeps hold_hi throughout.
    task automatic applyStimulus(input logic [1:0] vop, input logic [31:0] va,
                                 input logic [31:0] vb, input logic [31:0] exp_hi,
                                 input logic [31:0] exp_lo, input string name,
                                 input int mode, input logic [31:0] hold_hi);
        exp_t e;
        int   k;
        int   busy_cycles;
        bit   seen;
        e.hi   = exp_hi;
        e.lo   = exp_lo;
        e.name = name;
        sb_q.push_back(e);
        start = 1'b1;
        op    = vop;
        a     = va;
        b     = vb;
        if (mode == 1) begin
            hi_we = 1'b1;
            wdata = 32'h1111_1111;
        end
        @(posedge clk);
        k           = 0;
        busy_cycles = 0;
        seen        = 1'b0;
        while (!seen && k < 100) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                start = 1'b0;
                hi_we = 1'b0;
                a     = '0;
                b     = '0;
                if (mode == 1) begin
                    checkOutput({name, "_hi_hold_at_start"}, 64'(hi), 64'(hold_hi));
                end
            end
            if (mode == 1 && k == 10) begin
                start = 1'b1;
                op    = 2'b00;
                a     = '1;
                b     = '1;
                hi_we = 1'b1;
                lo_we = 1'b1;
                wdata = 32'h2222_2222;
            end
            if (mode == 1 && k == 11) begin
                start = 1'b0;
                hi_we = 1'b0;
                lo_we = 1'b0;
                checkOutput({name, "_hi_hold_mid_calc"}, 64'(hi), 64'(hold_hi));
            end
            if (busy) begin
                busy_cycles++;
            end
            if (done) begin
                seen = 1'b1;
                checkOutput({name, "_done_latency"}, 64'(k), 64'(DONE_INDEX));
                checkOutput({name, "_busy_cycles"}, 64'(busy_cycles), 64'(BUSY_COUNT));
            end
        end
        checkOutput({name, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    // Hard stop in case something blocks the main sequence
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence
    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_hilo", {hi, lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Multiplies, issued back to back so later ones start from DONE
        applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max", 0, '0);
        applyStimulus(2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg3x7", 0, '0);
        applyStimulus(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minxmin", 0, '0);
        applyStimulus(2'b00, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, "multu_shift4", 0, '0);

        // Divides, including the zero divisor and the overflowing signed case
        applyStimulus(2'b10, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, "divu_7by2", 0, '0);
        applyStimulus(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2", 0, '0);
        applyStimulus(2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7byneg2", 0, '0);
        applyStimulus(2'b10, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, "divu_100by7", 0, '0);
        applyStimulus(2'b11, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, "div_by_zero", 0, '0);
        applyStimulus(2'b10, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, "divu_by_zero", 0, '0);
        applyStimulus(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_min_by_neg1", 0, '0);

        // MTHI/MTLO while not busy
        hi_we = 1'b1;
        wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        hi_we = 1'b0;
        checkOutput("mthi", 64'(hi), 64'hA5A5_A5A5);
        lo_we = 1'b1;
        wdata = 32'h5A5A_5A5A;
        @(negedge clk);
        lo_we = 1'b0;
        checkOutput("mtlo", 64'(lo), 64'h5A5A_5A5A);
        checkOutput("mthi_kept", 64'(hi), 64'hA5A5_A5A5);

        // Writes coinciding with start, and a second start plus writes mid-CALC
        applyStimulus(2'b10, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, "divu_interfered", 1, 32'hA5A5_A5A5);

        // Reset in the middle of CALC aborts the operation and clears HI/LO
        start = 1'b1;
        op    = 2'b00;
        a     = '1;
        b     = '1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        checkOutput("abort_hilo", {hi, lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(2'b00, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, "multu_3x5_after_reset", 0, '0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
